// File: rtl/aes_pkg.sv
// Shared AES constants, types and the round-constant table used by the forward
// and inverse key schedules.
package aes_pkg;

    localparam int unsigned NB     = 4;
    localparam int unsigned NK     = 4;
    localparam int unsigned NR     = 10;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEY_W  = NB * WORD_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;

    // w0 occupies the MSBs; within a word, byte 0 is the MSB byte.
    typedef struct packed {
        word_t w0;
        word_t w1;
        word_t w2;
        word_t w3;
    } key_s;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic byte_t rcon(input logic [3:0] r);
        byte_t rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Key handshake bundle between the key store / inverse cipher and the reverse key schedule.
interface aes_inv_key_sched_if #(
    parameter int unsigned RND_W = 4
) ();

    logic               start;
    aes_pkg::key_s      key_in;
    logic               busy;
    aes_pkg::key_s      key_out;
    logic [RND_W-1:0]   round_out;
    logic               key_valid;
    logic               key_ready;
    logic               done;

    modport master (
        output start, key_in, key_ready,
        input  busy, key_out, round_out, key_valid, done
    );

    modport slave (
        input  start, key_in, key_ready,
        output busy, key_out, round_out, key_valid, done
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in, one byte out, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t sub_c
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_c = SBOX[in_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: loads the round-10 key and emits rounds 10..0,
// deriving each earlier key combinationally from the current one.
module aes_inv_key_sched #(
    parameter int unsigned NR    = 10,
    parameter int unsigned RND_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_key_sched_if.slave   bus
);

    import aes_pkg::*;

    if (NR != aes_pkg::NR || RND_W < 4) begin : g_param_check
        $error("aes_inv_key_sched supports only NR = 10 with RND_W >= 4");
    end

    state_e           state_q, state_d;
    key_s             key_q,   key_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             valid_q, valid_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    word_t p0, p1, p2, p3;
    word_t rot_c;
    word_t sub_c;
    key_s  prev_c;
    logic  hs_c;

    // Undo one expansion step: later words first, then w0 through SubWord/RotWord.
    always_comb begin
        p3     = key_q.w3 ^ key_q.w2;
        p2     = key_q.w2 ^ key_q.w1;
        p1     = key_q.w1 ^ key_q.w0;
        rot_c  = {p3[23:0], p3[31:24]};
        p0     = key_q.w0 ^ sub_c ^ {rcon(4'(round_q)), 24'h000000};
        prev_c = '{w0: p0, w1: p1, w2: p2, w3: p3};
    end

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte (rot_c[31-8*i -: 8]),
            .sub_c   (sub_c[31-8*i -: 8])
        );
    end

    assign hs_c = valid_q && bus.key_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key_in;
                    round_d = RND_W'(NR);
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs_c) begin
                    if (round_q != '0) begin
                        key_d   = prev_c;
                        round_d = round_q - RND_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.key_out   = key_q;
    assign bus.round_out = round_q;
    assign bus.key_valid = valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for the reverse AES-128 key schedule; expected keys come from an
// independent forward key expansion plus FIPS-197 A.1 constants.
module tb_aes_inv_key_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_inv_key_sched_if #(.RND_W(4)) bus ();

    aes_inv_key_sched #(.NR(10), .RND_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [0:255][7:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:10][7:0] RC_T = 88'h00_01_02_04_08_10_20_40_80_1b_36;

    localparam logic [127:0] K0_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K9_FIPS  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_k [11];
    logic [127:0] got_k [11];
    logic [3:0]   got_r [11];
    int           n_got, stable_errs, valid_cycles;
    bit           done_seen, timed_out;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX_T[w[31:24]], SBOX_T[w[23:16]], SBOX_T[w[15:8]], SBOX_T[w[7:0]]};
    endfunction

    // Forward expansion from the cipher key; exp_k[r] is the round-r key.
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {RC_T[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        bus.key_in = k;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // Drains one sequence, recording handshaked keys; mode 1 applies random and 5-cycle stalls.
    task automatic consume(input int mode, input bit inject);
        int          stall = 0;
        bit          prev_stall = 1'b0;
        logic [127:0] hk = '0;
        logic [3:0]   hr = '0;
        bit          last;
        n_got = 0; stable_errs = 0; valid_cycles = 0; done_seen = 1'b0; timed_out = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            last = 1'b0;
            if (inject && cyc == 2) begin
                bus.start  = 1'b1;
                bus.key_in = '1;
            end else if (inject && cyc == 3) begin
                bus.start  = 1'b0;
            end
            if (stall > 0) begin
                bus.key_ready = 1'b0;
                stall--;
            end else begin
                bus.key_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (bus.key_valid) begin
                valid_cycles++;
                if (prev_stall && (bus.key_out !== hk || bus.round_out !== hr)) stable_errs++;
                hk = bus.key_out;
                hr = bus.round_out;
                prev_stall = !bus.key_ready;
                if (bus.key_ready) begin
                    if (n_got < 11) begin
                        got_k[n_got] = bus.key_out;
                        got_r[n_got] = bus.round_out;
                    end
                    n_got++;
                    if (mode == 1 && (n_got == 3 || n_got == 7)) stall = 5;
                    last = (bus.round_out == 4'd0);
                end
            end else begin
                prev_stall = 1'b0;
            end
            tick();
            if (last) begin
                done_seen = bus.done && !bus.key_valid;
                timed_out = 1'b0;
                break;
            end
        end
        bus.key_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.key_in = '0; bus.key_ready = 1'b0;
        tick(); tick();
        n_checks++; if (bus.key_out !== 128'h0) begin n_fail++; $display("FAIL reset_key_out: got %h expected 0", bus.key_out); end
        n_checks++; if (bus.round_out !== 4'd0) begin n_fail++; $display("FAIL reset_round: got %0d expected 0", bus.round_out); end
        n_checks++; if ({bus.key_valid, bus.busy, bus.done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got valid/busy/done %b expected 000", {bus.key_valid, bus.busy, bus.done}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips();
        expand(K0_FIPS);
        do_start(K10_FIPS);
        n_checks++; if (!(bus.key_valid === 1'b1 && bus.round_out === 4'd10 && bus.busy === 1'b1)) begin
            n_fail++; $display("FAIL fips_latency: got valid=%b round=%0d busy=%b expected 1/10/1", bus.key_valid, bus.round_out, bus.busy); end
        consume(0, 1'b0);
        n_checks++; if (timed_out || n_got != 11) begin n_fail++; $display("FAIL fips_count: got %0d keys timeout=%b expected 11", n_got, timed_out); end
        n_checks++; if (got_k[0] !== K10_FIPS) begin n_fail++; $display("FAIL fips_r10: got %h expected %h", got_k[0], K10_FIPS); end
        n_checks++; if (got_k[1] !== K9_FIPS) begin n_fail++; $display("FAIL fips_r9: got %h expected %h", got_k[1], K9_FIPS); end
        n_checks++; if (got_k[9] !== K1_FIPS) begin n_fail++; $display("FAIL fips_r1: got %h expected %h", got_k[9], K1_FIPS); end
        n_checks++; if (got_k[10] !== K0_FIPS) begin n_fail++; $display("FAIL fips_r0: got %h expected %h", got_k[10], K0_FIPS); end
        for (int i = 0; i < 11; i++) begin
            n_checks++; if (got_k[i] !== exp_k[10-i] || got_r[i] !== 4'(10-i)) begin
                n_fail++; $display("FAIL fips_seq[%0d]: got r%0d %h expected r%0d %h", i, got_r[i], got_k[i], 10-i, exp_k[10-i]); end
        end
        n_checks++; if (!done_seen) begin n_fail++; $display("FAIL fips_done: got done=%b valid=%b expected 1/0", bus.done, bus.key_valid); end
        n_checks++; if (valid_cycles != 11) begin n_fail++; $display("FAIL fips_valid_cycles: got %0d expected 11", valid_cycles); end
        tick();
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL fips_done_pulse: got done=%b busy=%b expected 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_backpressure();
        expand(K0_FIPS);
        do_start(K10_FIPS);
        consume(1, 1'b0);
        n_checks++; if (timed_out || stable_errs != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls timeout=%b expected 0", stable_errs, timed_out); end
        for (int i = 0; i < 11; i++) begin
            n_checks++; if (got_k[i] !== exp_k[10-i] || got_r[i] !== 4'(10-i)) begin
                n_fail++; $display("FAIL bp_seq[%0d]: got r%0d %h expected r%0d %h", i, got_r[i], got_k[i], 10-i, exp_k[10-i]); end
        end
        n_checks++; if (!done_seen) begin n_fail++; $display("FAIL bp_done: got done=%b expected 1", bus.done); end
        tick();
    endtask

    task automatic test_start_ignored();
        expand(K0_FIPS);
        do_start(K10_FIPS);
        consume(0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            n_checks++; if (got_k[i] !== exp_k[10-i] || got_r[i] !== 4'(10-i)) begin
                n_fail++; $display("FAIL ign_seq[%0d]: got r%0d %h expected r%0d %h", i, got_r[i], got_k[i], 10-i, exp_k[10-i]); end
        end
        n_checks++; if (timed_out || n_got != 11 || !done_seen) begin n_fail++; $display("FAIL ign_done: got %0d keys done=%b expected 11/1", n_got, done_seen); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        expand(K0_FIPS);
        do_start(K10_FIPS);
        bus.key_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.key_valid && bus.round_out == 4'd6) begin hit = 1'b1; break; end
            tick();
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL rmid_reach6: got round %0d expected 6", bus.round_out); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.key_out !== 128'h0 || bus.round_out !== 4'd0 || bus.key_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async: got key=%h r=%0d v=%b busy=%b expected 0", bus.key_out, bus.round_out, bus.key_valid, bus.busy); end
        tick();
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done: got %b expected 0", bus.done); end
        rst = 1'b0;
        bus.key_ready = 1'b0;
        tick();
        do_start(K10_FIPS);
        consume(0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            n_checks++; if (got_k[i] !== exp_k[10-i] || got_r[i] !== 4'(10-i)) begin
                n_fail++; $display("FAIL rmid_seq[%0d]: got r%0d %h expected r%0d %h", i, got_r[i], got_k[i], 10-i, exp_k[10-i]); end
        end
        tick();
    endtask

    task automatic test_zero_key();
        do_start(128'h0);
        consume(0, 1'b0);
        n_checks++; if (got_k[1] !== 128'h55636363_00000000_00000000_00000000 || got_r[1] !== 4'd9) begin
            n_fail++; $display("FAIL zero_r9: got r%0d %h expected r9 55636363000000000000000000000000", got_r[1], got_k[1]); end
        tick();
    endtask

    task automatic test_random();
        logic [127:0] k0;
        for (int n = 0; n < 3; n++) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            expand(k0);
            do_start(exp_k[10]);
            consume(0, 1'b0);
            for (int i = 0; i < 11; i++) begin
                n_checks++; if (got_k[i] !== exp_k[10-i]) begin
                    n_fail++; $display("FAIL rand%0d_seq[%0d]: got %h expected %h", n, i, got_k[i], exp_k[10-i]); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bit hit = 1'b0;
        expand(K0_FIPS);
        do_start(K10_FIPS);
        bus.key_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.key_valid && bus.round_out == 4'd0) begin hit = 1'b1; break; end
            tick();
        end
        tick();
        n_checks++; if (!hit || bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got done=%b reached=%b expected 1/1", bus.done, hit); end
        bus.key_ready = 1'b0;
        bus.key_in    = K10_FIPS;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        n_checks++; if (bus.key_valid !== 1'b1 || bus.round_out !== 4'd10 || bus.key_out !== K10_FIPS || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_reload: got v=%b r=%0d key=%h done=%b expected 1/10/%h/0", bus.key_valid, bus.round_out, bus.key_out, bus.done, K10_FIPS); end
        consume(0, 1'b0);
        n_checks++; if (timed_out || got_k[10] !== K0_FIPS) begin n_fail++; $display("FAIL b2b_r0: got %h expected %h", got_k[10], K0_FIPS); end
        tick();
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.key_in = '0; bus.key_ready = 1'b0;
        test_reset();
        test_fips();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_zero_key();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
